// File: rtl/vx_tensor_dpu_sched.sv
// Round-robin scheduler sharing one fixed-latency tensor DPU between NUM_REQS requesters.
// One op in flight; operands registered at grant, result returned over a per-requester valid/ready.
module vx_tensor_dpu_sched #(
  parameter int NUM_REQS       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQS-1:0]     req_valid,
  output logic [NUM_REQS-1:0]     req_ready,
  input  logic [NUM_REQS*256-1:0] req_a,
  input  logic [NUM_REQS*256-1:0] req_b,
  input  logic [NUM_REQS*512-1:0] req_c,
  output logic [NUM_REQS-1:0]     rsp_valid,
  input  logic [NUM_REQS-1:0]     rsp_ready,
  output logic [511:0]            rsp_d,
  output logic                    dpu_valid_in,
  input  logic                    dpu_ready_in,
  output logic [255:0]            dpu_a,
  output logic [255:0]            dpu_b,
  output logic [511:0]            dpu_c,
  input  logic                    dpu_valid_out,
  input  logic [511:0]            dpu_d,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [31:0]             perf_ops,
  output logic [1:0]              dbg_state
);

  localparam int IDW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready and dpu_valid_in are combinational; rsp_valid/rsp_d stay stable until rsp_ready.
  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [255:0]     dpu_a_q, dpu_a_d, dpu_b_q, dpu_b_d;
  logic [511:0]     dpu_c_q, dpu_c_d, rsp_d_q, rsp_d_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      perf_ops_q, perf_ops_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   scan_idx;
  logic             rsp_fire;
  logic             grant_en;

  // First valid requester strictly after the last winner, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQS);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    rsp_fire     = (state_q == S_RESP) && rsp_ready[owner_q];
    grant_en     = (state_q == S_IDLE) || rsp_fire;
    req_ready    = '0;
    if (grant_en && gnt_found && reset_n) req_ready[gnt_idx] = 1'b1;
    rsp_valid    = '0;
    if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
    dpu_valid_in = (state_q == S_ISSUE) && dpu_ready_in;

    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    dpu_a_d    = dpu_a_q;
    dpu_b_d    = dpu_b_q;
    dpu_c_d    = dpu_c_q;
    rsp_d_d    = rsp_d_q;
    timeout_d  = timeout_q;
    perf_ops_d = perf_ops_q;

    case (state_q)
      S_IDLE: ;
      S_ISSUE: begin
        if (dpu_ready_in) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
        if (dpu_valid_out) begin
          rsp_d_d = dpu_d;
          state_d = S_RESP;
        end else if (wait_cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          perf_ops_d = perf_ops_q + 32'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A result with no op waiting for it means the DPU and scheduler disagree.
    if (dpu_valid_out && (state_q != S_WAIT)) timeout_d = 1'b1;

    if (grant_en && gnt_found) begin
      dpu_a_d  = req_a[gnt_idx*256 +: 256];
      dpu_b_d  = req_b[gnt_idx*256 +: 256];
      dpu_c_d  = req_c[gnt_idx*512 +: 512];
      owner_d  = gnt_idx;
      rr_ptr_d = gnt_idx;
      state_d  = S_ISSUE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= IDW'(NUM_REQS - 1);
      wait_cnt_q <= '0;
      dpu_a_q    <= '0;
      dpu_b_q    <= '0;
      dpu_c_q    <= '0;
      rsp_d_q    <= '0;
      timeout_q  <= 1'b0;
      perf_ops_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      dpu_a_q    <= dpu_a_d;
      dpu_b_q    <= dpu_b_d;
      dpu_c_q    <= dpu_c_d;
      rsp_d_q    <= rsp_d_d;
      timeout_q  <= timeout_d;
      perf_ops_q <= perf_ops_d;
    end
  end

  assign dpu_a       = dpu_a_q;
  assign dpu_b       = dpu_b_q;
  assign dpu_c       = dpu_c_q;
  assign rsp_d       = rsp_d_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_q;
  assign perf_ops    = perf_ops_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vx_tensor_dpu_sched.sv
// Bench for vx_tensor_dpu_sched: requester agent, latency-3 DPU model, response scoreboard.
module tb_vx_tensor_dpu_sched;
  localparam int N   = 4;
  localparam int L   = 3;
  localparam int TMO = 16;
  localparam int W   = 2 + 512;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*256-1:0] req_a = '0, req_b = '0;
  logic [N*512-1:0] req_c = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '1;
  logic [511:0]   rsp_d;
  logic           dpu_valid_in;
  logic           dpu_ready_in = 1'b1;
  logic [255:0]   dpu_a, dpu_b;
  logic [511:0]   dpu_c;
  logic           dpu_valid_out;
  logic [511:0]   dpu_d;
  logic           busy, timeout_err;
  logic [31:0]    perf_ops;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int grant_log[$];
  int pend_cnt[N];
  int served[N];
  logic mute = 1'b0;
  logic [511:0] hold_d;

  always #5 clk = ~clk;

  vx_tensor_dpu_sched #(.NUM_REQS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d),
    .dpu_valid_in(dpu_valid_in), .dpu_ready_in(dpu_ready_in),
    .dpu_a(dpu_a), .dpu_b(dpu_b), .dpu_c(dpu_c),
    .dpu_valid_out(dpu_valid_out), .dpu_d(dpu_d),
    .busy(busy), .timeout_err(timeout_err), .perf_ops(perf_ops),
    .dbg_state(dbg_state)
  );

  function automatic logic [255:0] fill256(input logic [31:0] v);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] fill512(input logic [31:0] v);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] hmma(input logic [255:0] a, input logic [255:0] b,
                                        input logic [511:0] c);
    logic [511:0] d;
    logic [31:0]  s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = c[(i*4+j)*32 +: 32];
        for (int k = 0; k < 2; k++) s = s + a[(i*2+k)*32 +: 32] * b[(k*4+j)*32 +: 32];
        d[(i*4+j)*32 +: 32] = s;
      end
    return d;
  endfunction

  // DPU model: shifts dpu_valid_in every cycle, result L cycles later.
  logic [L-1:0] pv;
  logic [511:0] pd [L];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      for (int k = 0; k < L; k++) pd[k] <= '0;
    end else begin
      pv    <= {pv[L-2:0], dpu_valid_in};
      pd[0] <= hmma(dpu_a, dpu_b, dpu_c);
      for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
    end
  end
  assign dpu_valid_out = pv[L-1] & ~mute;
  assign dpu_d         = pd[L-1];

  // Requester agent: drives at negedge, records accepts at negedge+4.
  // Tiles: A=i+1, B=2, C=10*i+served[i]  =>  D = 4*(i+1) + 10*i + served[i].
  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (pend_cnt[i] != 0);
      req_a[i*256 +: 256]   = fill256(32'(i + 1));
      req_b[i*256 +: 256]   = fill256(32'd2);
      req_c[i*512 +: 512]   = fill512(32'(10 * i + served[i]));
    end
    #4;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          exp_q.push_back({2'(i), fill512(32'(4 * (i + 1) + 10 * i + served[i]))});
          served[i]++;
          pend_cnt[i]--;
        end
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each response fire.
  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #4;
    if (reset_n) begin
      checks++;
      if ($countones(rsp_valid) > 1) begin
        errors++;
        $display("FAIL rsp_onehot actual=%b required=at most one bit", rsp_valid);
      end
      checks++;
      if ($countones(req_ready) > 1 || (busy && rsp_valid == '0 && req_ready != '0)) begin
        errors++;
        $display("FAIL req_ready_rule actual=%b busy=%0b required=0 or one-hot outside ISSUE/WAIT",
                 req_ready, busy);
      end
      checks++;
      if (dpu_valid_in && !dpu_ready_in) begin
        errors++;
        $display("FAIL dpu_strobe_not_ready actual=1 required=0");
      end
      checks++;
      if (busy !== (dbg_state != 2'd0)) begin
        errors++;
        $display("FAIL busy_vs_state actual=%0b required=%0b", busy, dbg_state != 2'd0);
      end
      for (int o = 0; o < N; o++) begin
        if (rsp_valid[o] && rsp_ready[o]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected actual=owner %0d required=no response", o);
          end else begin
            e = exp_q.pop_front();
            if ({2'(o), rsp_d} !== e) begin
              errors++;
              $display("FAIL rsp_data actual=owner %0d d=%0h required=owner %0d d=%0h",
                       o, rsp_d, e[W-1 -: 2], e[511:0]);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  function automatic int pend_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend_cnt[i];
    return s;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || pend_total() != 0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain actual=busy %0b queued %0d required=idle within 300 cycles",
               name, busy, exp_q.size());
    end
    step();
  endtask

  task automatic wait_ready(input string name, input int r);
    int n = 0;
    while (!req_ready[r] && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s_wait_ready actual=0 required=req_ready[%0d] within 50 cycles", name, r);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) pend_cnt[i] = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      pend_cnt[i] = 0;
      served[i]   = 0;
    end
    step();
    step();
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_timeout", 512'(timeout_err), 512'd0);
    chk("rst_perf", 512'(perf_ops), 512'd0);
    chk("rst_dpu_valid_in", 512'(dpu_valid_in), 512'd0);
    chk("rst_rsp_valid", 512'(rsp_valid), 512'd0);
    chk("rst_dpu_a", 512'(dpu_a), 512'd0);
    chk("rst_rsp_d", rsp_d, 512'd0);
    reset_n = 1'b1;
    step();

    // Single op from requester 2: D = 3*2*2 + 20 = 32 per element.
    pend_cnt[2] = 1;
    step();
    chk("t1_req_ready_t", 512'(req_ready), 512'(4'b0100));
    step();
    chk("t1_dpu_valid_t1", 512'(dpu_valid_in), 512'd1);
    step();
    step();
    step();
    chk("t1_rsp_valid_t4", 512'(rsp_valid), 512'd0);
    step();
    chk("t1_rsp_valid_t5", 512'(rsp_valid), 512'(4'b0100));
    chk("t1_rsp_d", rsp_d, fill512(32'd32));
    drain("t1");
    chk("t1_perf", 512'(perf_ops), 512'd1);

    // Round-robin over all four, two ops each, from reset.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) pend_cnt[i] = 2;
    drain("t2");
    chk("t2_grants", 512'(grant_log.size()), 512'd8);
    for (int g = 0; g < 8; g++)
      if (g < grant_log.size()) chk($sformatf("t2_grant_%0d", g), 512'(grant_log[g]), 512'(g % 4));
    chk("t2_perf", 512'(perf_ops), 512'd8);

    // DPU not ready while the op sits in ISSUE.
    dpu_ready_in = 1'b0;
    pend_cnt[1] = 1;
    wait_ready("t3", 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t3_hold_%0d", c), 512'(dpu_valid_in), 512'd0);
    end
    dpu_ready_in = 1'b1;
    #1;
    chk("t3_strobe", 512'(dpu_valid_in), 512'd1);
    step();
    chk("t3_strobe_once", 512'(dpu_valid_in), 512'd0);
    drain("t3");

    // Response back-pressure, then same-cycle grant on fire.
    rsp_ready[3] = 1'b0;
    pend_cnt[3] = 1;
    n = 0;
    while (!rsp_valid[3] && n < 50) begin
      step();
      n++;
    end
    chk("t4_rsp_seen", 512'(rsp_valid), 512'(4'b1000));
    chk("t4_rsp_d", rsp_d, fill512(32'd48));
    hold_d = rsp_d;
    pend_cnt[0] = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("t4_valid_%0d", c), 512'(rsp_valid), 512'(4'b1000));
      chk($sformatf("t4_d_%0d", c), rsp_d, hold_d);
      chk($sformatf("t4_noready_%0d", c), 512'(req_ready), 512'd0);
    end
    rsp_ready[3] = 1'b1;
    #1;
    chk("t4_same_cycle_grant", 512'(req_ready), 512'(4'b0001));
    drain("t4");

    // Timeout with a silent DPU, then reset mid-WAIT.
    mute = 1'b1;
    pend_cnt[1] = 1;
    n = 0;
    while (!dpu_valid_in && n < 50) begin
      step();
      n++;
    end
    chk("t5_strobe_seen", 512'(dpu_valid_in), 512'd1);
    for (int c = 0; c < 16; c++) step();
    chk("t5_timeout_pre", 512'(timeout_err), 512'd0);
    step();
    chk("t5_timeout_set", 512'(timeout_err), 512'd1);
    step();
    step();
    chk("t5_timeout_sticky", 512'(timeout_err), 512'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_busy", 512'(busy), 512'd0);
    chk("t5_rst_timeout", 512'(timeout_err), 512'd0);
    chk("t5_rst_perf", 512'(perf_ops), 512'd0);
    chk("t5_rst_req_ready", 512'(req_ready), 512'd0);
    chk("t5_rst_rsp_valid", 512'(rsp_valid), 512'd0);
    chk("t5_rst_dpu_valid_in", 512'(dpu_valid_in), 512'd0);
    mute = 1'b0;
    grant_log.delete();
    for (int i = 0; i < N; i++) pend_cnt[i] = 1;
    step();
    step();
    chk("t5_in_reset_ready", 512'(req_ready), 512'd0);
    reset_n = 1'b1;
    step();
    chk("t5_first_winner", 512'(grant_log.size() > 0 ? grant_log[0] : -1), 512'd0);
    drain("t5");
    chk("t5_perf", 512'(perf_ops), 512'd4);

    // Counter wrap.
    force dut.perf_ops_q = 32'hFFFF_FFFF;
    step();
    release dut.perf_ops_q;
    step();
    chk("t6_preload", 512'(perf_ops), 512'(32'hFFFF_FFFF));
    pend_cnt[2] = 1;
    drain("t6");
    chk("t6_wrap", 512'(perf_ops), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
